// File: rtl/micro_sequencer.sv
// micro_sequencer
// ----------------
// Microprogram sequencer for the control-signal decoder stage. It holds the
// micro-PC (upc), addresses an external combinational microcode ROM, and
// keeps an instruction register (IR) loaded from the data bus. The packed
// control word goes straight to the decoder's val_in input. rs, rd and
// opcode come from the IR.
//
// Microword layout: {seq_op[1:0], next[UADDR_W-1:0], ctrl[CW_SZ-1:0]}
//   seq_op 00 NEXT      upc+1 (modulo 2^UADDR_W)
//   seq_op 01 JUMP      next
//   seq_op 10 BRZ       next if flag_z, else upc+1
//   seq_op 11 DISPATCH  {opcode, 2'b00}, using the IR held before the edge
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   level, leaves IDLE
//   stall      in   freezes sequencing for the cycle while in RUN
//   flag_z     in   ALU zero flag, sampled at the decision edge
//   bus_in     in   data bus, captured into the IR
//   uaddr      out  ROM address (equals upc)
//   urom_data  in   microword read from the ROM at uaddr
//   ctrl_word  out  control word to the decoder (0 outside unstalled RUN)
//   rs         out  IR[1:0]
//   rd         out  IR[3:2]
//   opcode     out  IR[OP_W+3:4]
//   halted     out  high in HALT
//   ucycle_cnt out  retired-microword counter (only with USEQ_PERF_CNT_EN)
//
// Optional feature macro: USEQ_PERF_CNT_EN adds the 16-bit saturating
// ucycle_cnt output. With the macro undefined, the port and counter are absent.

module micro_sequencer #(
  parameter int CW_SZ     = 22,
  parameter int UADDR_W   = 6,
  parameter int OP_W      = 4,
  parameter int IR_LD_BIT = 9,
  parameter int HALT_ADDR = 63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      flag_z,
  input  logic [OP_W+3:0]           bus_in,
  output logic [UADDR_W-1:0]        uaddr,
  input  logic [CW_SZ+UADDR_W+1:0]  urom_data,
  output logic [CW_SZ-1:0]          ctrl_word,
  output logic [1:0]                rs,
  output logic [1:0]                rd,
  output logic [OP_W-1:0]           opcode,
`ifdef USEQ_PERF_CNT_EN
  output logic [15:0]               ucycle_cnt,
`endif
  output logic                      halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [1:0] SEQ_NEXT     = 2'b00;
  localparam logic [1:0] SEQ_JUMP     = 2'b01;
  localparam logic [1:0] SEQ_BRZ      = 2'b10;
  localparam logic [1:0] SEQ_DISPATCH = 2'b11;

  localparam logic [UADDR_W-1:0] HALT_UADDR = UADDR_W'(HALT_ADDR);

  state_t              r_state;
  logic [UADDR_W-1:0]  r_upc;
  logic [OP_W+3:0]     r_ir;
  logic                r_halted;

  logic [1:0]          w_seq_op;
  logic [UADDR_W-1:0]  w_next;
  logic [CW_SZ-1:0]    w_ctrl;
  logic [UADDR_W-1:0]  w_upc_inc;
  logic [UADDR_W-1:0]  w_next_upc;
  logic                w_retire;

  assign w_seq_op  = urom_data[CW_SZ+UADDR_W+1 -: 2];
  assign w_next    = urom_data[CW_SZ+UADDR_W-1 -: UADDR_W];
  assign w_ctrl    = urom_data[CW_SZ-1:0];
  assign w_upc_inc = r_upc + {{(UADDR_W-1){1'b0}}, 1'b1};

  // A microword retires on every unstalled RUN cycle.
  assign w_retire  = (r_state == ST_RUN) && !stall;

  // Next micro-address selection. The dispatch target uses the IR as it is
  // before this edge, so an IR load in the same microword does not affect it.
  always_comb begin
    w_next_upc = w_upc_inc;
    case (w_seq_op)
      SEQ_NEXT:     w_next_upc = w_upc_inc;
      SEQ_JUMP:     w_next_upc = w_next;
      SEQ_BRZ:      w_next_upc = flag_z ? w_next : w_upc_inc;
      SEQ_DISPATCH: w_next_upc = UADDR_W'({r_ir[OP_W+3:4], 2'b00});
      default:      w_next_upc = w_upc_inc;
    endcase
  end

  // Sequencer FSM: state, micro-PC, instruction register and halted flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_upc    <= {UADDR_W{1'b0}};
      r_ir     <= {(OP_W+4){1'b0}};
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // upc is already 0 here, so the first microword is ROM[0].
          if (start) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            r_upc <= w_next_upc;
            if (w_ctrl[IR_LD_BIT]) begin
              r_ir <= bus_in;
            end
            if (w_next_upc == HALT_UADDR) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          // Only reset leaves HALT.
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_upc    <= {UADDR_W{1'b0}};
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef USEQ_PERF_CNT_EN
  logic [15:0] r_ucycle_cnt;

  // Saturating count of retired microwords. It includes the edge that enters HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ucycle_cnt <= 16'h0000;
    end else if (w_retire && (r_ucycle_cnt != 16'hFFFF)) begin
      r_ucycle_cnt <= r_ucycle_cnt + 16'h0001;
    end else begin
      r_ucycle_cnt <= r_ucycle_cnt;
    end
  end

  assign ucycle_cnt = r_ucycle_cnt;
`endif

  // The control word follows the ROM combinationally. It is blanked when the
  // sequencer is not retiring, so the decoder sees no transfers.
  assign ctrl_word = w_retire ? w_ctrl : {CW_SZ{1'b0}};
  assign uaddr     = r_upc;
  assign rs        = r_ir[1:0];
  assign rd        = r_ir[3:2];
  assign opcode    = r_ir[OP_W+3:4];
  assign halted    = r_halted;

endmodule
